// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard control slice.
// Holds the instruction width, counter width default, the execute
// operand forward-select encodings and the hazard FSM state encodings.
package hazard_ctrl_pkg;

  localparam int unsigned INST_SIZE = 32;
  localparam int unsigned CNT_W_DEF = 32;

  // Execute operand source select
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,  // register file
    FWD_ME = 2'd1,  // memory-stage bypass
    FWD_WB = 2'd2   // writeback bypass
  } fwd_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_PEND  = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard bundle between the datapath and hazard_ctrl.
// master: datapath side (drives register ids, enables, branch and
//         memory handshake; receives forward selects, stalls, flushes,
//         performance counters and the memory-timeout error).
// slave:  hazard_ctrl side.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = hazard_ctrl_pkg::CNT_W_DEF
);
  logic [4:0]       rs1_de, rs2_de;
  logic [4:0]       rs1_ex, rs2_ex;
  logic [4:0]       rd_ex;
  logic             mem_reg_ex;
  logic [4:0]       rd_me;
  logic             we_me;
  logic [4:0]       rd_wb;
  logic             we_wb;
  logic             pc_r;
  logic             mem_req, mem_rdy;
  logic [1:0]       hu_rs1, hu_rs2;
  logic             stall_fe, stall_de, stall_ex, stall_me;
  logic             flush_de, flush_ex;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_err;

  modport master (
    output rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex, mem_reg_ex,
           rd_me, we_me, rd_wb, we_wb, pc_r, mem_req, mem_rdy,
    input  hu_rs1, hu_rs2, stall_fe, stall_de, stall_ex, stall_me,
           flush_de, flush_ex, stall_cnt, flush_cnt, mem_err
  );

  modport slave (
    input  rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex, mem_reg_ex,
           rd_me, we_me, rd_wb, we_wb, pc_r, mem_req, mem_rdy,
    output hu_rs1, hu_rs2, stall_fe, stall_de, stall_ex, stall_me,
           flush_de, flush_ex, stall_cnt, flush_cnt, mem_err
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding compare for one execute source operand.
// Ports: rs (execute source register), rd_me/we_me (memory-stage
// writer), rd_wb/we_wb (writeback writer), sel (operand source).
// The memory stage holds the younger result, so it wins over writeback.
// x0 is never forwarded.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_me,
  input  logic       we_me,
  input  logic [4:0] rd_wb,
  input  logic       we_wb,
  output fwd_e       sel
);

  always_comb begin
    sel = FWD_RF;
    if (we_me && (rd_me != '0) && (rd_me == rs))
      sel = FWD_ME;
    else if (we_wb && (rd_wb != '0) && (rd_wb == rs))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall,
// branch flush and data-memory wait handling, plus stall/flush
// performance counters and a sticky memory-timeout error.
// Ports: clk, rst (asynchronous, active-low), hz (hazard_ctrl_if.slave).
// Parameters: CNT_W (counter width), MEM_TMO (memory-wait cycle limit).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned MEM_TMO = 255
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_if.slave   hz
);

  localparam int unsigned     WAIT_W = (MEM_TMO < 2) ? 1 : $clog2(MEM_TMO + 1);
  localparam logic [WAIT_W-1:0] TMO  = WAIT_W'(MEM_TMO);

  state_e             state, state_nxt;
  logic               pend;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic [CNT_W-1:0]   stall_cnt, flush_cnt;
  logic               mem_err;
  logic               wait_stall, load_use;
  logic               s_fe, s_de, s_ex, s_me, f_de, f_ex;
  fwd_e               sel1, sel2;

  fwd_sel u_fwd_rs1 (
    .rs(hz.rs1_ex), .rd_me(hz.rd_me), .we_me(hz.we_me),
    .rd_wb(hz.rd_wb), .we_wb(hz.we_wb), .sel(sel1)
  );

  fwd_sel u_fwd_rs2 (
    .rs(hz.rs2_ex), .rd_me(hz.rd_me), .we_me(hz.we_me),
    .rd_wb(hz.rd_wb), .we_wb(hz.we_wb), .sel(sel2)
  );

  assign wait_stall = hz.mem_req && !hz.mem_rdy;
  assign load_use   = hz.mem_reg_ex && (hz.rd_ex != '0) &&
                      ((hz.rd_ex == hz.rs1_de) || (hz.rd_ex == hz.rs2_de));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:      if (wait_stall) state_nxt = MEM_WAIT;
      MEM_WAIT: if (hz.mem_rdy) state_nxt = (pend || hz.pc_r) ? BR_PEND : RUN;
      BR_PEND:  state_nxt = wait_stall ? MEM_WAIT : RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Outputs: memory wait > branch flush > load-use. The stall/flush
  // lines are forced low while reset is held.
  always_comb begin
    s_fe = 1'b0; s_de = 1'b0; s_ex = 1'b0; s_me = 1'b0;
    f_de = 1'b0; f_ex = 1'b0;
    if (rst) begin
      unique case (state)
        RUN: begin
          if (wait_stall) begin
            s_fe = 1'b1; s_de = 1'b1; s_ex = 1'b1; s_me = 1'b1;
          end else if (hz.pc_r) begin
            f_de = 1'b1; f_ex = 1'b1;
          end else if (load_use) begin
            s_fe = 1'b1; s_de = 1'b1; f_ex = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!hz.mem_rdy) begin
            s_fe = 1'b1; s_de = 1'b1; s_ex = 1'b1; s_me = 1'b1;
          end
        end
        BR_PEND: begin
          // A fresh memory wait defers the owed flush; pend stays set.
          if (wait_stall) begin
            s_fe = 1'b1; s_de = 1'b1; s_ex = 1'b1; s_me = 1'b1;
          end else begin
            f_de = 1'b1; f_ex = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A branch resolved while the pipe is frozen on memory is remembered
  // and flushed once the wait completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pend <= 1'b0;
    else if ((state == BR_PEND) && !wait_stall)
      pend <= 1'b0;
    else if (hz.pc_r && ((state == MEM_WAIT) || ((state == RUN) && wait_stall)))
      pend <= 1'b1;
  end

  always_comb begin
    wait_nxt = '0;
    if ((state == MEM_WAIT) && !hz.mem_rdy)
      wait_nxt = (wait_cnt == TMO) ? wait_cnt : wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if ((state == MEM_WAIT) && (wait_nxt == TMO))
        mem_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (s_fe && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (f_ex && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.hu_rs1    = sel1;
  assign hz.hu_rs2    = sel2;
  assign hz.stall_fe  = s_fe;
  assign hz.stall_de  = s_de;
  assign hz.stall_ex  = s_ex;
  assign hz.stall_me  = s_me;
  assign hz.flush_de  = f_de;
  assign hz.flush_ex  = f_ex;
  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;
  assign hz.mem_err   = mem_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. Expected outputs are
// queued when a step is driven and compared when sampled on the falling
// edge; the counters and mem_err are tracked by a small bench model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) hz();

  hazard_ctrl #(.CNT_W(32), .MEM_TMO(255)) dut (
    .clk(clk),
    .rst(rst),
    .hz(hz.slave)
  );

  typedef struct {
    string       tag;
    logic [1:0]  h1, h2;
    logic [3:0]  st;   // {fe, de, ex, me}
    logic [1:0]  fl;   // {de, ex}
    logic        err;
    logic [31:0] sc, fc;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [31:0] e_sc = '0;
  logic [31:0] e_fc = '0;
  logic        e_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] h1, input logic [1:0] h2,
                      input logic [3:0] st, input logic [1:0] fl);
    exp_t e;
    e.tag = tag; e.h1 = h1; e.h2 = h2; e.st = st; e.fl = fl;
    e.err = e_err; e.sc = e_sc; e.fc = e_fc;
    sb.push_back(e);
  endtask

  task automatic observe();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ":hu_rs1"}, 32'(hz.hu_rs1), 32'(e.h1));
    chk({e.tag, ":hu_rs2"}, 32'(hz.hu_rs2), 32'(e.h2));
    chk({e.tag, ":stalls"}, 32'({hz.stall_fe, hz.stall_de, hz.stall_ex, hz.stall_me}), 32'(e.st));
    chk({e.tag, ":flushes"}, 32'({hz.flush_de, hz.flush_ex}), 32'(e.fl));
    chk({e.tag, ":mem_err"}, 32'(hz.mem_err), 32'(e.err));
    chk({e.tag, ":stall_cnt"}, hz.stall_cnt, e.sc);
    chk({e.tag, ":flush_cnt"}, hz.flush_cnt, e.fc);
  endtask

  // Inputs are already driven (just after a rising edge); sample on the
  // falling edge, then advance past the next rising edge and update model.
  task automatic step(input string tag, input logic [1:0] h1, input logic [1:0] h2,
                      input logic [3:0] st, input logic [1:0] fl);
    push(tag, h1, h2, st, fl);
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    if (rst) begin
      if (st[3] && (e_sc != '1)) e_sc++;
      if (fl[0] && (e_fc != '1)) e_fc++;
    end
  endtask

  task automatic idle();
    hz.rs1_de = '0; hz.rs2_de = '0; hz.rs1_ex = '0; hz.rs2_ex = '0;
    hz.rd_ex = '0; hz.mem_reg_ex = 1'b0; hz.rd_me = '0; hz.we_me = 1'b0;
    hz.rd_wb = '0; hz.we_wb = 1'b0; hz.pc_r = 1'b0;
    hz.mem_req = 1'b0; hz.mem_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    @(posedge clk); #1;

    // Reset held: every hazard source active, only forwarding may show.
    hz.rs1_ex = 5'd5; hz.rd_me = 5'd5; hz.we_me = 1'b1;
    hz.mem_req = 1'b1; hz.pc_r = 1'b1;
    hz.mem_reg_ex = 1'b1; hz.rd_ex = 5'd3; hz.rs1_de = 5'd3;
    step("rst_hold0", 2'd1, 2'd0, 4'b0000, 2'b00);
    step("rst_hold1", 2'd1, 2'd0, 4'b0000, 2'b00);
    idle();
    rst = 1'b1;
    step("rst_rel", 2'd0, 2'd0, 4'b0000, 2'b00);

    // Forwarding
    hz.rs1_ex = 5'd5; hz.rs2_ex = 5'd5; hz.rd_me = 5'd5; hz.we_me = 1'b1;
    hz.rd_wb = 5'd5; hz.we_wb = 1'b1;
    step("fwd_me", 2'd1, 2'd1, 4'b0000, 2'b00);
    hz.we_me = 1'b0;
    step("fwd_wb", 2'd2, 2'd2, 4'b0000, 2'b00);
    hz.rs1_ex = 5'd0;
    step("fwd_rs1_x0", 2'd0, 2'd2, 4'b0000, 2'b00);
    idle();
    hz.we_me = 1'b1; hz.we_wb = 1'b1;
    step("fwd_x0_dst", 2'd0, 2'd0, 4'b0000, 2'b00);
    hz.rs1_ex = 5'd4; hz.rs2_ex = 5'd9; hz.rd_me = 5'd4; hz.rd_wb = 5'd9;
    step("fwd_mix", 2'd1, 2'd2, 4'b0000, 2'b00);
    hz.rd_me = 5'd9;
    step("fwd_me_wins", 2'd0, 2'd1, 4'b0000, 2'b00);

    // Load-use
    idle();
    hz.mem_reg_ex = 1'b1; hz.rd_ex = 5'd7; hz.rs2_de = 5'd7;
    step("lu_rs2", 2'd0, 2'd0, 4'b1100, 2'b01);
    idle();
    step("lu_after", 2'd0, 2'd0, 4'b0000, 2'b00);
    hz.mem_reg_ex = 1'b1; hz.rd_ex = 5'd12; hz.rs1_de = 5'd12;
    step("lu_rs1", 2'd0, 2'd0, 4'b1100, 2'b01);
    hz.mem_reg_ex = 1'b0;
    step("lu_noload", 2'd0, 2'd0, 4'b0000, 2'b00);
    hz.mem_reg_ex = 1'b1; hz.rd_ex = 5'd0; hz.rs1_de = 5'd0;
    step("lu_x0", 2'd0, 2'd0, 4'b0000, 2'b00);

    // Memory wait with a branch resolved during the wait
    idle();
    hz.mem_req = 1'b1;
    step("mw_c1", 2'd0, 2'd0, 4'b1111, 2'b00);
    hz.pc_r = 1'b1;
    step("mw_c2", 2'd0, 2'd0, 4'b1111, 2'b00);
    hz.pc_r = 1'b0;
    step("mw_c3", 2'd0, 2'd0, 4'b1111, 2'b00);
    hz.mem_rdy = 1'b1;
    step("mw_c4", 2'd0, 2'd0, 4'b0000, 2'b00);
    idle();
    step("mw_c5", 2'd0, 2'd0, 4'b0000, 2'b11);
    step("mw_c6", 2'd0, 2'd0, 4'b0000, 2'b00);

    // Branch and load-use together: flush wins, no stall
    hz.pc_r = 1'b1; hz.mem_reg_ex = 1'b1; hz.rd_ex = 5'd7; hz.rs1_de = 5'd7;
    step("br_lu", 2'd0, 2'd0, 4'b0000, 2'b11);
    idle();
    step("br_lu_after", 2'd0, 2'd0, 4'b0000, 2'b00);

    // Memory timeout: 300 cycles without ready
    hz.mem_req = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      if (i == 257) e_err = 1'b1;
      step($sformatf("tmo_c%0d", i), 2'd0, 2'd0, 4'b1111, 2'b00);
    end
    hz.mem_rdy = 1'b1;
    step("tmo_rdy", 2'd0, 2'd0, 4'b0000, 2'b00);
    idle();
    step("err_sticky0", 2'd0, 2'd0, 4'b0000, 2'b00);
    step("err_sticky1", 2'd0, 2'd0, 4'b0000, 2'b00);

    // Asynchronous reset in the middle of a memory wait with a branch pending
    hz.mem_req = 1'b1;
    step("rw_c1", 2'd0, 2'd0, 4'b1111, 2'b00);
    hz.pc_r = 1'b1;
    step("rw_c2", 2'd0, 2'd0, 4'b1111, 2'b00);
    #2;
    rst = 1'b0;
    e_sc = '0; e_fc = '0; e_err = 1'b0;
    #1;
    push("async_rst", 2'd0, 2'd0, 4'b0000, 2'b00);
    observe();
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    step("post_rst0", 2'd0, 2'd0, 4'b0000, 2'b00);
    step("post_rst1", 2'd0, 2'd0, 4'b0000, 2'b00);
    hz.pc_r = 1'b1;
    step("post_rst_br", 2'd0, 2'd0, 4'b0000, 2'b11);
    idle();
    step("post_rst_idle", 2'd0, 2'd0, 4'b0000, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
